strip_ws2812_multi: RTL and testbench

//  Multi-channel WS2812/SK6812 strip driver: CHANNELS strips driven in lockstep from per-channel pixel RAMs.

---
 rtl/strip_ws2812_multi_pkg.sv | 26 ++
 rtl/strip_ws2812_multi_chan_ram.sv | 31 +++
 rtl/strip_ws2812_multi.sv | 210 +++++++++++++++++++++
 tb/tb_strip_ws2812_multi.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strip_ws2812_multi_pkg.sv
// Shared types, timing defaults and pixel packing helpers for the multi-strip WS2812 driver.
package strip_ws2812_multi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StBits,
    StGap
  } state_e;

  localparam int unsigned DEF_T_BIT   = 64;
  localparam int unsigned DEF_T0H     = 21;
  localparam int unsigned DEF_T1H     = 42;
  localparam int unsigned DEF_T_RESET = 2600;

  // Bits per pixel on the wire.
  function automatic int unsigned bpp_of(input int unsigned rgbw);
    return (rgbw != 0) ? 32 : 24;
  endfunction

  // Host word {W,R,G,B} -> transmit order {G,R,B,W}; 24-bit pixels keep the upper 24 bits.
  function automatic logic [31:0] pack_pixel(input logic [31:0] data);
    return {data[15:8], data[23:16], data[7:0], data[31:24]};
  endfunction

endpackage

// File: rtl/strip_ws2812_multi_chan_ram.sv
// Per-strip pixel store: one write port, one registered read port.
module strip_ws2812_multi_chan_ram #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Writes beyond the last pixel are dropped; reads have one cycle of latency.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && (32'(i_wr_addr) < DEPTH)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/strip_ws2812_multi.sv
// Triggered multi-strip WS2812/SK6812 driver: shared FSM and counters, per-strip RAM and shifter.
module strip_ws2812_multi
  import strip_ws2812_multi_pkg::*;
#(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned LED_COUNT    = 256,
  parameter int unsigned RGBW         = 0,
  parameter int unsigned REVERSE      = 0,
  parameter int unsigned T_BIT        = DEF_T_BIT,
  parameter int unsigned T0H          = DEF_T0H,
  parameter int unsigned T1H          = DEF_T1H,
  parameter int unsigned T_RESET      = DEF_T_RESET,
  parameter int unsigned AUTO_REFRESH = 0,
  localparam int unsigned ADDR_W      = $clog2(LED_COUNT),
  localparam int unsigned CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                led_clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [CHAN_W-1:0]   wr_chan_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [31:0]         wr_data_i,
  input  logic                frame_start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [CHANNELS-1:0] led_data_o
);

  localparam int unsigned BPP  = bpp_of(RGBW);
  localparam int unsigned PH_W = $clog2(T_BIT);
  localparam int unsigned BI_W = $clog2(BPP);
  localparam int unsigned RC_W = $clog2(T_RESET + 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = (REVERSE != 0) ? ADDR_W'(LED_COUNT - 1) : '0;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = (REVERSE != 0) ? '0 : ADDR_W'(LED_COUNT - 1);

  if ((T0H >= T1H) || (T1H >= T_BIT) || (LED_COUNT < 2)) begin : g_param_check
    $error("strip_ws2812_multi: need T0H < T1H < T_BIT and LED_COUNT >= 2");
  end

  state_e            r_state;
  logic [PH_W-1:0]   r_phase;
  logic [BI_W-1:0]   r_bit_idx;
  logic [RC_W-1:0]   r_rst_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_pending;
  logic              r_load;
  logic [BPP-1:0]    r_shift [CHANNELS];
  logic [CHANNELS-1:0] r_led;

  logic [BPP-1:0]    w_rd_data [CHANNELS];
  logic [BPP-1:0]    w_cur [CHANNELS];
  logic [31:0]       w_packed;
  logic [BPP-1:0]    w_wr_word;
  logic              w_bit_end;
  logic              w_pix_end;
  logic              w_last_pix;
  logic              w_gap_end;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_packed = pack_pixel(wr_data_i);

  if (RGBW != 0) begin : g_rgbw
    assign w_wr_word = w_packed;
  end else begin : g_rgb
    logic w_unused_w;
    assign w_wr_word  = w_packed[31:8];
    assign w_unused_w = ^w_packed[7:0];
  end

  // Bit/pixel/gap boundaries and the RAM read request (first pixel in FETCH, next during last bit).
  always_comb begin
    w_bit_end  = (r_phase == PH_W'(T_BIT - 1));
    w_pix_end  = (r_state == StBits) && w_bit_end && (r_bit_idx == '0);
    w_last_pix = (r_addr == LAST_ADDR);
    w_gap_end  = (r_state == StGap) && (r_rst_cnt == RC_W'(T_RESET));
    w_rd_en    = 1'b0;
    w_rd_addr  = r_addr;
    if (r_state == StFetch) begin
      w_rd_en   = 1'b1;
      w_rd_addr = FIRST_ADDR;
    end else if (w_pix_end && !w_last_pix) begin
      w_rd_en   = 1'b1;
      w_rd_addr = (REVERSE != 0) ? r_addr - ADDR_W'(1) : r_addr + ADDR_W'(1);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic w_we;
    assign w_we = wr_en_i && (wr_chan_i == CHAN_W'(c));

    strip_ws2812_multi_chan_ram #(
      .DEPTH  (LED_COUNT),
      .WIDTH  (BPP),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .i_clk     (led_clk_i),
      .i_wr_en   (w_we),
      .i_wr_addr (wr_addr_i),
      .i_wr_data (w_wr_word),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data[c])
    );

    // The first cycle of a pixel uses the RAM output directly; the shifter takes over afterwards.
    assign w_cur[c] = r_load ? w_rd_data[c] : r_shift[c];
  end

  // Frame sequencer: state, shared counters, busy/done/pending flags.
  always_ff @(posedge led_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_phase   <= '0;
      r_bit_idx <= '0;
      r_rst_cnt <= '0;
      r_addr    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pending <= 1'b0;
      r_load    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_load <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (frame_start_i) begin
            r_state   <= StFetch;
            r_busy    <= 1'b1;
            r_pending <= 1'b0;
          end
        end
        StFetch: begin
          if (frame_start_i) r_pending <= 1'b1;
          r_state   <= StBits;
          r_addr    <= FIRST_ADDR;
          r_phase   <= '0;
          r_bit_idx <= BI_W'(BPP - 1);
          r_load    <= 1'b1;
        end
        StBits: begin
          if (frame_start_i) r_pending <= 1'b1;
          if (w_bit_end) begin
            r_phase <= '0;
            if (r_bit_idx == '0) begin
              r_bit_idx <= BI_W'(BPP - 1);
              if (w_last_pix) begin
                r_state   <= StGap;
                r_rst_cnt <= '0;
              end else begin
                r_addr <= w_rd_addr;
                r_load <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx - BI_W'(1);
            end
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        StGap: begin
          if (w_gap_end) begin
            r_done <= 1'b1;
            // A request landing on the final gap cycle merges into the restart.
            if (r_pending || frame_start_i || (AUTO_REFRESH != 0)) begin
              r_state   <= StFetch;
              r_pending <= 1'b0;
            end else begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end
          end else begin
            if (frame_start_i) r_pending <= 1'b1;
            r_rst_cnt <= r_rst_cnt + RC_W'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Per-strip shift registers and the registered serial outputs.
  always_ff @(posedge led_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_led <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_shift[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (r_state == StBits) begin
          if (w_bit_end) begin
            r_shift[c] <= w_cur[c] << 1;
          end else if (r_load) begin
            r_shift[c] <= w_rd_data[c];
          end
        end
        r_led[c] <= (r_state == StBits) &&
                    (r_phase < (w_cur[c][BPP-1] ? PH_W'(T1H) : PH_W'(T0H)));
      end
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign led_data_o = r_led;

endmodule

// File: tb/tb_strip_ws2812_multi.sv
// Directed bench for strip_ws2812_multi: three configurations sharing one clock and reset.
module tb_strip_ws2812_multi;

  localparam int TBIT = 64;
  localparam int H0   = 21;
  localparam int H1   = 42;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        wr_en_a, wr_en_b, wr_en_c;
  logic        start_a, start_b, start_c;
  logic [1:0]  wr_chan;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [3:0]  led_a;
  logic [0:0]  led_b;
  logic [2:0]  led_c;

  logic [95:0] exp_stream [4];

  // 4 strips, 2 pixels, RGB.
  strip_ws2812_multi #(.CHANNELS(4), .LED_COUNT(2)) dut_a (
    .led_clk_i(clk), .rst_i(rst), .wr_en_i(wr_en_a), .wr_chan_i(wr_chan),
    .wr_addr_i(wr_addr[0]), .wr_data_i(wr_data), .frame_start_i(start_a),
    .busy_o(busy_a), .done_o(done_a), .led_data_o(led_a)
  );

  // 1 strip, 2 pixels, RGBW.
  strip_ws2812_multi #(.CHANNELS(1), .LED_COUNT(2), .RGBW(1)) dut_b (
    .led_clk_i(clk), .rst_i(rst), .wr_en_i(wr_en_b), .wr_chan_i(wr_chan[0]),
    .wr_addr_i(wr_addr[0]), .wr_data_i(wr_data), .frame_start_i(start_b),
    .busy_o(busy_b), .done_o(done_b), .led_data_o(led_b)
  );

  // 3 strips, 3 pixels, reversed order.
  strip_ws2812_multi #(.CHANNELS(3), .LED_COUNT(3), .REVERSE(1)) dut_c (
    .led_clk_i(clk), .rst_i(rst), .wr_en_i(wr_en_c), .wr_chan_i(wr_chan),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .frame_start_i(start_c),
    .busy_o(busy_c), .done_o(done_c), .led_data_o(led_c)
  );

  function automatic logic [3:0] led_of(input int sel);
    case (sel)
      0:       return led_a;
      1:       return {3'b000, led_b};
      default: return {1'b0, led_c};
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; leaves the bus idle one cycle later.
  task automatic write_px(input int sel, input int ch, input int addr, input logic [31:0] data);
    wr_chan = 2'(ch);
    wr_addr = 2'(addr);
    wr_data = data;
    case (sel)
      0:       wr_en_a = 1'b1;
      1:       wr_en_b = 1'b1;
      default: wr_en_c = 1'b1;
    endcase
    @(negedge clk);
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
    wr_en_c = 1'b0;
  endtask

  task automatic start_frame(input int sel, output int t0);
    t0 = cyc;
    case (sel)
      0:       start_a = 1'b1;
      1:       start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic wait_rise(input int sel, input int t0, input string tag);
    int n;
    n = 0;
    while (led_of(sel) == 4'd0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_first_edge_latency"}, 64'(cyc - t0), 64'd3);
  endtask

  // Samples every strip for each bit period and compares the exact high/low shape.
  task automatic check_stream(input int sel, input int nch, input int nbits, input string tag);
    logic [63:0] sv [4];
    logic [3:0]  v;
    logic [63:0] expv;
    int          h;
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < TBIT; k++) begin
        v = led_of(sel);
        for (int c = 0; c < 4; c++) sv[c][63-k] = v[c];
        @(negedge clk);
      end
      for (int c = 0; c < nch; c++) begin
        h    = exp_stream[c][95-b] ? H1 : H0;
        expv = ~(64'hFFFF_FFFF_FFFF_FFFF >> h);
        chk($sformatf("%s_ch%0d_bit%0d", tag, c, b), sv[c], expv);
      end
    end
  endtask

  task automatic wait_done(input int sel, input int t0, input int exp_len, input string tag);
    int   n;
    logic gap_hi;
    n      = 0;
    gap_hi = 1'b0;
    while (!done_of(sel) && n < 20000) begin
      if (led_of(sel) != 4'd0) gap_hi = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({tag, "_gap_low"}, 64'(gap_hi), 64'd0);
    chk({tag, "_done_cycle"}, 64'(cyc - t0), 64'(exp_len));
    chk({tag, "_busy_at_done"}, 64'(busy_of(sel)), 64'd0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(done_of(sel)), 64'd0);
  endtask

  task automatic load_a();
    write_px(0, 0, 0, 32'h00FF_000F);
    write_px(0, 0, 1, 32'h0012_3456);
    write_px(0, 1, 0, 32'h0080_01C3);
    write_px(0, 1, 1, 32'h7700_FF00);
    write_px(0, 2, 0, 32'h0055_AA33);
    write_px(0, 2, 1, 32'h00FF_FFFF);
    write_px(0, 3, 0, 32'h0000_0000);
    write_px(0, 3, 1, 32'h000F_F081);
    exp_stream[0] = {48'h00FF0F_341256, 48'h0};
    exp_stream[1] = {48'h0180C3_FF0000, 48'h0};
    exp_stream[2] = {48'hAA5533_FFFFFF, 48'h0};
    exp_stream[3] = {48'h000000_F00F81, 48'h0};
  endtask

  initial begin
    int   t0;
    int   nd, d1, d2, e2, bl;
    logic flag;

    rst     = 1'b1;
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
    wr_en_c = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    wr_chan = '0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) @(negedge clk);

    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset_led_%0d", s), 64'(led_of(s)), 64'd0);
      chk($sformatf("reset_busy_%0d", s), 64'(busy_of(s)), 64'd0);
      chk($sformatf("reset_done_%0d", s), 64'(done_of(s)), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Four strips in lockstep, each with its own data.
    load_a();
    start_frame(0, t0);
    chk("t2_busy_next_cycle", 64'(busy_a), 64'd1);
    wait_rise(0, t0, "t2");
    check_stream(0, 4, 48, "t2");
    wait_done(0, t0, 2 * 24 * 64 + 2600 + 3, "t2");

    // Two extra requests while busy merge into one follow-on frame.
    start_frame(0, t0);
    repeat (100) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (10) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    nd = 0;
    d1 = -1;
    d2 = -1;
    e2 = -1;
    bl = -1;
    for (int n = 0; n < 15000; n++) begin
      if (done_a) begin
        nd++;
        if (nd == 1) d1 = cyc;
        else if (nd == 2) d2 = cyc;
      end
      if (d1 >= 0 && e2 < 0 && cyc > d1 && led_a != 4'd0) e2 = cyc;
      if (!busy_a) begin
        bl = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("t4_done_count", 64'(nd), 64'd2);
    chk("t4_first_done", 64'(d1 - t0), 64'd5675);
    chk("t4_second_edge", 64'(e2 - d1), 64'd2);
    chk("t4_second_done", 64'(d2 - d1), 64'd5674);
    chk("t4_busy_drop", 64'(bl), 64'(d2));
    repeat (10) @(negedge clk);
    chk("t4_idle_after", 64'(busy_a), 64'd0);

    // Asynchronous reset in the middle of a high phase.
    start_frame(0, t0);
    repeat (200) @(negedge clk);
    chk("t5_high_before_reset", 64'(led_a), 64'hF);
    #2 rst = 1'b1;
    #1;
    chk("t5_led_async", 64'(led_a), 64'd0);
    chk("t5_busy_async", 64'(busy_a), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    flag = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done_a || busy_a || led_a != 4'd0) flag = 1'b1;
    end
    chk("t5_quiet_after_reset", 64'(flag), 64'd0);
    load_a();
    start_frame(0, t0);
    wait_rise(0, t0, "t5");
    check_stream(0, 4, 48, "t5");
    wait_done(0, t0, 2 * 24 * 64 + 2600 + 3, "t5");

    // RGBW: 32 bits per pixel, W last.
    write_px(1, 0, 0, 32'hA511_2233);
    write_px(1, 0, 1, 32'h3CC0_017E);
    exp_stream[0] = {64'h221133A5_01C07E3C, 32'h0};
    start_frame(1, t0);
    wait_rise(1, t0, "t3");
    check_stream(1, 1, 64, "t3");
    wait_done(1, t0, 2 * 32 * 64 + 2600 + 3, "t3");

    // Reverse order; out-of-range address and channel writes are dropped.
    write_px(2, 0, 0, 32'h0001_0203);
    write_px(2, 0, 1, 32'h0010_2030);
    write_px(2, 0, 2, 32'h00C0_0CF0);
    write_px(2, 1, 0, 32'h00FF_0000);
    write_px(2, 1, 1, 32'h0000_00FF);
    write_px(2, 1, 2, 32'h0000_FF00);
    write_px(2, 2, 0, 32'h0081_1842);
    write_px(2, 2, 1, 32'h0000_0000);
    write_px(2, 2, 2, 32'h007E_E799);
    write_px(2, 0, 3, 32'hFFFF_FFFF);
    write_px(2, 3, 0, 32'hFFFF_FFFF);
    write_px(2, 3, 2, 32'hFFFF_FFFF);
    exp_stream[0] = {72'h0CC0F0_201030_020103, 24'h0};
    exp_stream[1] = {72'hFF0000_0000FF_00FF00, 24'h0};
    exp_stream[2] = {72'hE77E99_000000_188142, 24'h0};
    start_frame(2, t0);
    wait_rise(2, t0, "t6");
    check_stream(2, 3, 72, "t6");
    wait_done(2, t0, 3 * 24 * 64 + 2600 + 3, "t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
